// File: rtl/inv_key_scheduler.sv
// AES-128 inverse key scheduler: expands the cipher key forward to round 10,
// then replays round keys 10..0 through a valid/ready handshake using the inverse recurrence.

module aes_g_word (
    input  logic [31:0] w,
    input  logic [3:0]  round,
    output logic [31:0] g
);
    // Forward S-box, byte 0x00 in the most significant position
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sub_byte(input logic [7:0] b);
        return SBOX[{~b, 3'b000} +: 8];
    endfunction

    logic [31:0] rot;
    logic [7:0]  rcon;

    always_comb begin
        rcon = 8'h00;
        case (round)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    assign rot = {w[23:0], w[31:24]};
    assign g   = {sub_byte(rot[31:24]) ^ rcon, sub_byte(rot[23:16]),
                  sub_byte(rot[15:8]), sub_byte(rot[7:0])};
endmodule

// state  | meaning
// IDLE   | waiting for key_load
// EXPAND | forward steps r = 1..10 on the key register
// EMIT   | presenting round key cnt; inverse step on each accept
module inv_key_scheduler #(
    parameter int NUM_ROUNDS  = 10,
    parameter bit EMIT_ROUND0 = 1'b1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [127:0] key_in,
    input  logic         key_load,
    output logic         busy,
    output logic [127:0] subkey,
    output logic [3:0]   subkey_round,
    output logic         subkey_valid,
    input  logic         subkey_ready,
    output logic         done
);
    generate
        if (NUM_ROUNDS != 10) begin : g_bad_cfg
            $error("inv_key_scheduler supports only NUM_ROUNDS = 10 (AES-128)");
        end
    endgenerate

    localparam logic [3:0] FINAL_ROUND = 4'd10;
    localparam logic [3:0] LAST_ROUND  = EMIT_ROUND0 ? 4'd0 : 4'd1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        EMIT   = 2'd2
    } state_t;

    state_t       state, state_nxt;
    logic [127:0] key_q, key_nxt;
    logic [3:0]   cnt, cnt_nxt;
    logic         done_q, done_nxt;

    logic [31:0]  x0, x1, x2, x3;
    logic [31:0]  inv_w3, g_in, g_out;
    logic [127:0] fwd_key, inv_key;

    assign x0 = key_q[127:96];
    assign x1 = key_q[95:64];
    assign x2 = key_q[63:32];
    assign x3 = key_q[31:0];

    // One g instance: forward uses W3 of the stored key, inverse uses the recovered W3
    assign inv_w3 = x3 ^ x2;
    assign g_in   = (state == EMIT) ? inv_w3 : x3;

    aes_g_word u_g (
        .w     (g_in),
        .round (cnt),
        .g     (g_out)
    );

    always_comb begin
        logic [31:0] f0, f1, f2;
        f0      = x0 ^ g_out;
        f1      = f0 ^ x1;
        f2      = f1 ^ x2;
        fwd_key = {f0, f1, f2, f2 ^ x3};
        inv_key = {x0 ^ g_out, x1 ^ x0, x2 ^ x1, inv_w3};
    end

    always_comb begin
        state_nxt = state;
        key_nxt   = key_q;
        cnt_nxt   = cnt;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (key_load) begin
                    key_nxt   = key_in;
                    cnt_nxt   = 4'd1;
                    state_nxt = EXPAND;
                end
            end
            EXPAND: begin
                key_nxt = fwd_key;
                if (cnt == FINAL_ROUND) begin
                    state_nxt = EMIT;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            EMIT: begin
                if (subkey_ready) begin
                    if (cnt == LAST_ROUND) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        key_nxt = inv_key;
                        cnt_nxt = cnt - 4'd1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state  <= IDLE;
            key_q  <= '0;
            cnt    <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            key_q  <= key_nxt;
            cnt    <= cnt_nxt;
            done_q <= done_nxt;
        end
    end

    assign busy         = (state != IDLE);
    assign subkey_valid = (state == EMIT);
    assign subkey       = key_q;
    assign subkey_round = cnt;
    assign done         = done_q;
endmodule

// File: tb/tb_inv_key_scheduler.sv
// Bench for inv_key_scheduler: scoreboard of expected round keys from an
// independent key-expansion model (S-box derived from GF(2^8) inversion).

module tb_inv_key_scheduler;
    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] ZERO_KEY = 128'h0;

    logic         clk;
    logic         reset_n;
    logic [127:0] key_in;
    logic         key_load;
    logic         subkey_ready;
    logic         sel;

    logic         busy0, valid0, done0, busy1, valid1, done1;
    logic [127:0] sk0, sk1;
    logic [3:0]   rd0, rd1;

    logic         b, v, dn;
    logic [127:0] sk;
    logic [3:0]   rd;

    typedef struct {
        logic [3:0]   rnd;
        logic [127:0] key;
    } exp_t;

    exp_t         q[$];
    logic [127:0] rk[11];
    int           checks = 0;
    int           failures = 0;

    inv_key_scheduler #(.NUM_ROUNDS(10), .EMIT_ROUND0(1'b1)) dut0 (
        .clk          (clk),
        .reset_n      (reset_n),
        .key_in       (key_in),
        .key_load     (key_load & ~sel),
        .busy         (busy0),
        .subkey       (sk0),
        .subkey_round (rd0),
        .subkey_valid (valid0),
        .subkey_ready (subkey_ready & ~sel),
        .done         (done0)
    );

    inv_key_scheduler #(.NUM_ROUNDS(10), .EMIT_ROUND0(1'b0)) dut1 (
        .clk          (clk),
        .reset_n      (reset_n),
        .key_in       (key_in),
        .key_load     (key_load & sel),
        .busy         (busy1),
        .subkey       (sk1),
        .subkey_round (rd1),
        .subkey_valid (valid1),
        .subkey_ready (subkey_ready & sel),
        .done         (done1)
    );

    assign b  = sel ? busy1  : busy0;
    assign v  = sel ? valid1 : valid0;
    assign dn = sel ? done1  : done0;
    assign sk = sel ? sk1    : sk0;
    assign rd = sel ? rd1    : rd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] bb);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ a;
            a  = xt(a);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rol8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    function automatic logic [7:0] sb_calc(input logic [7:0] x);
        logic [7:0] sq = x;
        logic [7:0] inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ rol8(inv, 1) ^ rol8(inv, 2) ^ rol8(inv, 3) ^ rol8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [31:0] g_model(input logic [31:0] w, input int r);
        logic [31:0] rot = {w[23:0], w[31:24]};
        logic [7:0]  rc = 8'h01;
        for (int i = 2; i <= r; i++) rc = xt(rc);
        return {sb_calc(rot[31:24]) ^ rc, sb_calc(rot[23:16]), sb_calc(rot[15:8]), sb_calc(rot[7:0])};
    endfunction

    task automatic expand_model(input logic [127:0] key);
        logic [31:0] w0, w1, w2, w3;
        rk[0] = key;
        for (int r = 1; r <= 10; r++) begin
            {w0, w1, w2, w3} = rk[r-1];
            w0 = w0 ^ g_model(w3, r);
            w1 = w1 ^ w0;
            w2 = w2 ^ w1;
            w3 = w3 ^ w2;
            rk[r] = {w0, w1, w2, w3};
        end
    endtask

    task automatic run_session(input logic [127:0] key, input bit rnd, input bit junk,
                               input int rst_rnd, input bit preloaded, input bit chain,
                               input logic [127:0] next_key);
        int   n;
        int   guard;
        bit   junk_done;
        int   last;
        exp_t e;
        last = sel ? 1 : 0;
        expand_model(key);
        q.delete();
        for (int r = 10; r >= last; r--) q.push_back('{rnd: 4'(r), key: rk[r]});
        if (!preloaded) begin
            @(negedge clk);
            key_in   = key;
            key_load = 1'b1;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
            key_load = 1'b0;
            key_in   = key;
            if (junk && n == 5) begin
                key_load = 1'b1;
                key_in   = ~key;
            end
        end while (!v && n < 30);
        chk("latency", 128'(n), 128'(11));
        guard = 0;
        junk_done = 1'b0;
        while (q.size() > 0) begin
            if (!v) begin
                chk("valid_hold", 128'(v), 128'(1));
                break;
            end
            if (guard > 200) begin
                chk("emit_timeout", 128'(guard), 128'(200));
                break;
            end
            e = q[0];
            chk("subkey", sk, e.key);
            chk("round", 128'(rd), 128'(e.rnd));
            if (key == FIPS_KEY) begin
                case (rd)
                    4'd10: chk("fips_r10", sk, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
                    4'd9:  chk("fips_r9", sk, 128'hac7766f319fadc2128d12941575c006e);
                    4'd1:  chk("fips_r1", sk, 128'ha0fafe1788542cb123a339392a6c7605);
                    4'd0:  chk("fips_r0", sk, FIPS_KEY);
                    default: ;
                endcase
            end
            if (key == ZERO_KEY && rd == 4'd1) chk("zero_r1", sk, 128'h62636363626363636263636362636363);
            if (rst_rnd == int'(e.rnd)) begin
                reset_n      = 1'b0;
                subkey_ready = 1'b0;
                key_load     = 1'b0;
                @(negedge clk);
                chk("rst_busy", 128'(b), 128'(0));
                chk("rst_valid", 128'(v), 128'(0));
                chk("rst_subkey", sk, 128'(0));
                chk("rst_round", 128'(rd), 128'(0));
                chk("rst_done", 128'(dn), 128'(0));
                reset_n = 1'b1;
                q.delete();
                return;
            end
            key_load = 1'b0;
            key_in   = key;
            if (junk && !junk_done && e.rnd == 4'd7) begin
                key_load  = 1'b1;
                key_in    = ~key;
                junk_done = 1'b1;
            end
            subkey_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (subkey_ready) void'(q.pop_front());
            @(negedge clk);
            guard++;
        end
        key_load = 1'b0;
        key_in   = key;
        chk("done_pulse", 128'(dn), 128'(1));
        chk("valid_after", 128'(v), 128'(0));
        subkey_ready = 1'b0;
        if (chain) begin
            key_in   = next_key;
            key_load = 1'b1;
        end else begin
            @(negedge clk);
            chk("done_once", 128'(dn), 128'(0));
        end
    endtask

    initial begin
        reset_n      = 1'b0;
        key_in       = '0;
        key_load     = 1'b0;
        subkey_ready = 1'b0;
        sel          = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 128'(b), 128'(0));
        chk("reset_valid", 128'(v), 128'(0));
        chk("reset_done", 128'(dn), 128'(0));
        chk("reset_subkey", sk, 128'(0));
        chk("reset_round", 128'(rd), 128'(0));
        reset_n = 1'b1;
        @(negedge clk);

        run_session(FIPS_KEY, 1'b0, 1'b0, -1, 1'b0, 1'b0, '0);
        run_session(FIPS_KEY, 1'b1, 1'b0, -1, 1'b0, 1'b0, '0);
        run_session(FIPS_KEY, 1'b0, 1'b1, -1, 1'b0, 1'b0, '0);
        run_session(FIPS_KEY, 1'b1, 1'b0, 5, 1'b0, 1'b0, '0);
        run_session(FIPS_KEY, 1'b0, 1'b0, -1, 1'b0, 1'b0, '0);
        run_session(ZERO_KEY, 1'b0, 1'b0, -1, 1'b0, 1'b0, '0);
        run_session({$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0, -1, 1'b0, 1'b0, '0);

        sel = 1'b1;
        @(negedge clk);
        run_session(FIPS_KEY, 1'b0, 1'b0, -1, 1'b0, 1'b1, ZERO_KEY);
        run_session(ZERO_KEY, 1'b1, 1'b0, -1, 1'b1, 1'b0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/inv_key_scheduler.md
Name: inv_key_scheduler

Overview:
Decryption-side counterpart of the AES-128 forward key schedule. It accepts the 128-bit cipher key and expands it forward internally to round key 10. It then replays the round keys in reverse order (10 down to 0), one per handshake, using the inverse key-expansion recurrence. It feeds the inverse-cipher datapath, which consumes round keys last-to-first.

Parameters:
NUM_ROUNDS, 10, number of AES rounds; only 10 (AES-128) is supported, and any other value is a configuration error.
EMIT_ROUND0, 1, 1 = emit round key 0 (the original cipher key) as the final output; 0 = stop after round key 1.

Ports:
clk  input  1  single clock, all logic on the rising edge
reset_n  input  1  synchronous, active-low reset
key_in  input  128  cipher key, word W0 in [127:96], W3 in [31:0]
key_load  input  1  start request; sampled only in IDLE
busy  output  1  high in every state other than IDLE
subkey  output  128  current round key, same word packing as key_in
subkey_round  output  4  round index of subkey (10..0)
subkey_valid  output  1  subkey/subkey_round are valid
subkey_ready  input  1  consumer accepts subkey when high with subkey_valid
done  output  1  one-cycle pulse after the last key is accepted

Behaviour:
- Reset (reset_n low at a clock edge) sets the following, regardless of state (including mid-EXPAND or mid-EMIT):
  - state IDLE
  - busy 0, subkey_valid 0, done 0
  - subkey 0, subkey_round 0
  - internal key register and counter 0
- Word function g(w, r) = SubWord(RotWord(w)) XOR {Rcon[r], 24'h0}, with Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36. It uses the codebase's existing g word-function module; a single instance is shared between directions through an input mux.
- Forward step, key r-1 (W0..W3) to key r:
  - X0 = W0 ^ g(W3, r)
  - X1 = X0 ^ W1
  - X2 = X1 ^ W2
  - X3 = X2 ^ W3
- Inverse step, key r (X0..X3) to key r-1:
  - W3 = X3 ^ X2
  - W2 = X2 ^ X1
  - W1 = X1 ^ X0
  - W0 = X0 ^ g(W3, r), where W3 is the value just computed
- IDLE:
  - key_load high captures key_in into the key register, sets cnt = 1 and moves to EXPAND.
  - Without key_load, the block stays in IDLE.
- EXPAND:
  - Each cycle applies the forward step with r = cnt, then increments cnt.
  - After the step with r = 10, the block moves to EMIT with subkey_round = 10 and subkey_valid = 1.
  - Latency: subkey_valid rises exactly 11 cycles after the key_load cycle.
- EMIT:
  - subkey holds the key register and subkey_round holds the current r.
  - subkey_valid stays 1, and outputs stay stable while subkey_ready is 0. Arbitrary stall length is allowed.
  - On valid & ready with r > last (last = 0 if EMIT_ROUND0 else 1): the inverse step with the current r is applied, r decrements, and subkey_valid stays 1. This gives one key per cycle under continuous ready.
  - On valid & ready with r == last: subkey_valid drops to 0, done pulses high for the next cycle and the state returns to IDLE.
- key_load while busy is ignored. It does not restart and does not corrupt the current sequence.
- key_load asserted in the same cycle as done is high is accepted, because the state is IDLE that cycle. Back-to-back sessions therefore cost one idle cycle.
- subkey_round never wraps. The counter is 4 bits, and values 11..15 are unreachable.

Test Plan:
1. FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, ready tied high -> subkey_valid exactly 11 cycles after key_load. Required outputs:
   - round 10: d014f9a8c9ee2589e13f0cc8b6630ca6
   - round 9: ac7766f319fadc2128d12941575c006e
   - round 1: a0fafe1788542cb123a339392a6c7605
   - round 0: the original key
   - done pulses once afterward.
2. Same key with subkey_ready random (~50%) -> identical key sequence. Outputs are stable during stalls, with no skipped or repeated rounds.
3. key_load pulsed during EXPAND and again during EMIT with a different key_in -> the sequence is unaffected and still matches scenario 1.
4. reset_n low mid-EMIT (at round 5) -> the next cycle shows IDLE, busy 0, subkey_valid 0 and subkey 0. A new key_load runs a full, correct sequence.
5. EMIT_ROUND0=0 -> the last emitted key is round 1 (a0fafe17...7605), then done. Also key_load asserted in the done cycle -> a new session starts, with valid 11 cycles later.
6. All-zero key -> round 1 key 62636363626363636263636362636363, and round 0 returns 00...00.
